// File: rtl/dmem_mmio_responder_if.sv
// CPU data-memory port bundle: write channel, read request and 1-cycle read return.
interface dmem_mmio_responder_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic                  w_enb;
    logic [3:0]            w_byte_enb;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_enb;
    logic [DATA_WIDTH-1:0] r_dat;

    modport master (
        output w_addr, w_dat, w_enb, w_byte_enb, r_addr, r_enb,
        input  r_dat
    );

    modport slave (
        input  w_addr, w_dat, w_enb, w_byte_enb, r_addr, r_enb,
        output r_dat
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Splits the CPU data port: lower half of the word space goes to bram32, upper half
// hits a tiny MMIO block (cycle counter, status/halt, byte TX FIFO).
module dmem_mmio_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TX_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_mmio_responder_if.slave  cpu,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_dat,
    output logic                  mem_w_enb,
    output logic [3:0]            mem_w_byte_enb,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  mem_r_enb,
    input  logic [DATA_WIDTH-1:0] mem_r_dat,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  halted,
    output logic                  pass
);
    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [1:0]  OFF_CYCLE     = 2'd0;
    localparam logic [1:0]  OFF_STATUS    = 2'd1;
    localparam logic [1:0]  OFF_TX_DATA   = 2'd2;
    localparam logic [1:0]  OFF_TX_STATUS = 2'd3;
    localparam logic [DATA_WIDTH-1:0] STATUS_MASK = DATA_WIDTH'(32'hFFFF_FF03);

    logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  rsel_mmio_q, rsel_mmio_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            fifo_mem [TX_DEPTH];

    logic                  w_mmio, r_mmio, full, empty, push, pop, do_push;
    logic [DATA_WIDTH-1:0] mmio_rd_c;

    assign w_mmio = cpu.w_addr[ADDR_WIDTH-1];
    assign r_mmio = cpu.r_addr[ADDR_WIDTH-1];

    // RAM half is a straight combinational pass-through
    assign mem_w_addr     = cpu.w_addr;
    assign mem_w_dat      = cpu.w_dat;
    assign mem_w_byte_enb = cpu.w_byte_enb;
    assign mem_w_enb      = cpu.w_enb & ~w_mmio;
    assign mem_r_addr     = cpu.r_addr;
    assign mem_r_enb      = cpu.r_enb & ~r_mmio;

    assign full     = (count_q == CNT_W'(TX_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = ~empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rptr_q];
    assign halted   = status_q[0];
    assign pass     = status_q[1];

    assign push    = cpu.w_enb & w_mmio & (cpu.w_addr[1:0] == OFF_TX_DATA) & cpu.w_byte_enb[0];
    assign pop     = tx_valid & tx_ready;
    assign do_push = push & (~full | pop);

    // Until the first read after reset there is nothing to return, so drive zero
    assign cpu.r_dat = !rvalid_q ? '0 : (rsel_mmio_q ? rdat_q : mem_r_dat);

    always_comb begin
        mmio_rd_c = '0;
        case (cpu.r_addr[1:0])
            OFF_CYCLE:     mmio_rd_c = cycle_q;
            OFF_STATUS:    mmio_rd_c = status_q;
            OFF_TX_DATA:   mmio_rd_c = DATA_WIDTH'(count_q);
            OFF_TX_STATUS: mmio_rd_c = DATA_WIDTH'({ovf_q, empty, full});
            default:       mmio_rd_c = '0;
        endcase
    end

    always_comb begin
        cycle_d     = cycle_q + DATA_WIDTH'(1);
        status_d    = status_q;
        rdat_d      = rdat_q;
        rsel_mmio_d = rsel_mmio_q;
        rvalid_d    = rvalid_q;
        ovf_d       = ovf_q;
        wptr_d      = wptr_q + PTR_W'(do_push);
        rptr_d      = rptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(do_push) - CNT_W'(pop);

        if (cpu.r_enb) begin
            rdat_d      = mmio_rd_c;
            rsel_mmio_d = r_mmio;
            rvalid_d    = 1'b1;
        end

        if (cpu.w_enb && w_mmio && cpu.w_addr[1:0] == OFF_STATUS) begin
            for (int i = 0; i < 4; i++) begin
                if (cpu.w_byte_enb[i]) status_d[8*i +: 8] = cpu.w_dat[8*i +: 8];
            end
            status_d = status_d & STATUS_MASK;
        end

        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (cpu.w_enb && w_mmio && cpu.w_addr[1:0] == OFF_TX_STATUS &&
                     cpu.w_byte_enb[0] && cpu.w_dat[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q     <= '0;
            status_q    <= '0;
            rdat_q      <= '0;
            rsel_mmio_q <= 1'b0;
            rvalid_q    <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            cycle_q     <= cycle_d;
            status_q    <= status_d;
            rdat_q      <= rdat_d;
            rsel_mmio_q <= rsel_mmio_d;
            rvalid_q    <= rvalid_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push && !rst) fifo_mem[wptr_q] <= cpu.w_dat[7:0];
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed plus randomized bench for dmem_mmio_responder against a queue-based model.
module tb_dmem_mmio_responder;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk, rst, tx_ready, tx_valid, halted, pass;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_dat, mem_r_dat;
    logic          mem_w_enb, mem_r_enb;
    logic [3:0]    mem_w_byte_enb;
    logic [7:0]    tx_data;

    dmem_mmio_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();

    dmem_mmio_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cpu(cpu_if.slave),
        .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
        .mem_w_byte_enb(mem_w_byte_enb), .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb),
        .mem_r_dat(mem_r_dat), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halted(halted), .pass(pass)
    );

    // bram32 stand-in driven only by the DUT's RAM-side outputs
    logic [DW-1:0] bram [4096];
    always @(posedge clk) begin
        if (mem_w_enb)
            for (int i = 0; i < 4; i++)
                if (mem_w_byte_enb[i]) bram[mem_w_addr][8*i +: 8] <= mem_w_dat[8*i +: 8];
        if (mem_r_enb) mem_r_dat <= bram[mem_r_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    logic [31:0] m_cycle, m_status, exp_rdat;
    logic        m_ovf;
    logic [7:0]  m_q [$];
    logic [31:0] ref_ram [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mmio_val(input logic [1:0] off);
        case (off)
            2'd0:    return m_cycle;
            2'd1:    return m_status;
            2'd2:    return 32'(m_q.size());
            default: return {29'b0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH};
        endcase
    endfunction

    task automatic model_step();
        logic        do_pop;
        logic [31:0] old, nv;
        if (rst) begin
            m_cycle = 0; m_status = 0; m_ovf = 0; exp_rdat = 0;
            m_q.delete();
            return;
        end
        if (cpu_if.r_enb) begin
            if (cpu_if.r_addr[AW-1]) exp_rdat = mmio_val(cpu_if.r_addr[1:0]);
            else exp_rdat = ref_ram.exists(int'(cpu_if.r_addr)) ? ref_ram[int'(cpu_if.r_addr)] : 32'h0;
        end
        do_pop = (m_q.size() != 0) && tx_ready;
        if (do_pop) void'(m_q.pop_front());
        if (cpu_if.w_enb) begin
            if (!cpu_if.w_addr[AW-1]) begin
                old = ref_ram.exists(int'(cpu_if.w_addr)) ? ref_ram[int'(cpu_if.w_addr)] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (cpu_if.w_byte_enb[i]) old[8*i +: 8] = cpu_if.w_dat[8*i +: 8];
                ref_ram[int'(cpu_if.w_addr)] = old;
            end else begin
                case (cpu_if.w_addr[1:0])
                    2'd1: begin
                        nv = m_status;
                        for (int i = 0; i < 4; i++)
                            if (cpu_if.w_byte_enb[i]) nv[8*i +: 8] = cpu_if.w_dat[8*i +: 8];
                        m_status = nv & 32'hFFFF_FF03;
                    end
                    2'd2: if (cpu_if.w_byte_enb[0]) begin
                        if (m_q.size() < DEPTH) m_q.push_back(cpu_if.w_dat[7:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd3: if (cpu_if.w_byte_enb[0] && cpu_if.w_dat[2]) m_ovf = 1'b0;
                    default: ;
                endcase
            end
        end
        m_cycle = m_cycle + 32'd1;
    endtask

    task automatic chk_outs();
        check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        check("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check("halted", 32'(halted), 32'(m_status[0]));
        check("pass", 32'(pass), 32'(m_status[1]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    task automatic idle_bus();
        cpu_if.w_enb = 0; cpu_if.r_enb = 0; cpu_if.w_byte_enb = 4'h0;
        cpu_if.w_addr = '0; cpu_if.w_dat = '0; cpu_if.r_addr = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_if.w_addr = a; cpu_if.w_dat = d; cpu_if.w_byte_enb = be; cpu_if.w_enb = 1;
        tick();
        cpu_if.w_enb = 0;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [31:0] want);
        cpu_if.r_addr = a; cpu_if.r_enb = 1;
        tick();
        cpu_if.r_enb = 0;
        check(tag, cpu_if.r_dat, exp_rdat);
        check({tag, "_const"}, cpu_if.r_dat, want);
    endtask

    initial begin
        idle_bus();
        tx_ready = 0; rst = 1;
        m_cycle = 0; m_status = 0; m_ovf = 0; exp_rdat = 0;
        tick(); tick();
        check("rst_rdat", cpu_if.r_dat, 32'h0);
        rst = 0;

        // RAM path
        for (int i = 0; i < 16; i++) do_write(AW'(i), 32'h1111_0000 + 32'(i), 4'hF);
        do_write(12'h010, 32'h0, 4'hF);
        do_write(12'h010, 32'hDEADBEEF, 4'b0011);
        do_read("ram_rd", 12'h010, 32'h0000BEEF);
        cpu_if.w_addr = 12'h801; cpu_if.w_enb = 1; #1;
        check("mmio_no_memw", 32'(mem_w_enb), 32'h0);
        cpu_if.w_enb = 0;

        // CYCLE
        rst = 1; tick(); rst = 0;
        repeat (4) tick();
        do_read("cycle4", 12'h800, 32'd4);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFF;
        do_read("cycle_max", 12'h800, 32'hFFFF_FFFF);
        do_read("cycle_wrap", 12'h800, 32'h0);

        // STATUS
        do_write(12'h801, 32'h00ABCD03, 4'hF);
        check("halted_set", 32'(halted), 32'h1);
        do_read("status_rd", 12'h801, 32'h00ABCD03);
        do_write(12'h801, 32'h0, 4'b0001);
        do_read("status_rd2", 12'h801, 32'h00ABCD00);

        // FIFO stream
        do_write(12'h802, 32'h41, 4'h1);
        do_write(12'h802, 32'h42, 4'h1);
        do_write(12'h802, 32'h43, 4'h1);
        do_read("tx_count", 12'h802, 32'd3);
        check("head_41", 32'(tx_data), 32'h41);
        tx_ready = 1;
        tick(); check("head_42", 32'(tx_data), 32'h42);
        tick(); check("head_43", 32'(tx_data), 32'h43);
        tick(); check("drained", 32'(tx_valid), 32'h0);
        do_read("txs_empty", 12'h803, 32'h2);

        // Overflow
        tx_ready = 0;
        for (int i = 0; i < 9; i++) do_write(12'h802, 32'h50 + 32'(i), 4'h1);
        do_read("txs_ovf", 12'h803, 32'h5);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", 32'(tx_data), 32'h50 + 32'(i));
            tick();
        end
        check("ovf_empty", 32'(tx_valid), 32'h0);
        tx_ready = 0;
        do_write(12'h803, 32'h4, 4'h1);
        do_read("ovf_clr", 12'h803, 32'h2);
        for (int i = 0; i < 8; i++) do_write(12'h802, 32'h60 + 32'(i), 4'h1);
        tx_ready = 1;
        do_write(12'h802, 32'h68, 4'h1);
        tx_ready = 0;
        do_read("full_pushpop", 12'h803, 32'h1);

        // Reset mid-stream with 4 queued
        tx_ready = 1; repeat (4) tick(); tx_ready = 0;
        do_write(12'h801, 32'h3, 4'h1);
        check("queued4", 32'(m_q.size()), 32'(dut.count_q));
        rst = 1; tick(); rst = 0;
        check("rst_valid", 32'(tx_valid), 32'h0);
        check("rst_rdat2", cpu_if.r_dat, 32'h0);
        do_read("rst_cycle", 12'h800, 32'h0);
        do_read("rst_status", 12'h801, 32'h0);
        do_read("rst_ram", 12'h010, 32'h0000BEEF);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic rd;
            idle_bus();
            rst = ($urandom_range(0, 99) == 0);
            tx_ready = 1'($urandom);
            rd = 0;
            if (!rst) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_if.w_enb = 1;
                    cpu_if.w_byte_enb = 4'($urandom);
                    cpu_if.w_dat = $urandom;
                    cpu_if.w_addr = $urandom_range(0, 1) == 1
                        ? AW'(12'h800 | 12'($urandom_range(0, 511)) << 2 | 12'($urandom_range(0, 3)))
                        : AW'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 1) == 1) begin
                    rd = 1;
                    cpu_if.r_enb = 1;
                    cpu_if.r_addr = $urandom_range(0, 1) == 1
                        ? AW'(12'h800 | 12'($urandom_range(0, 511)) << 2 | 12'($urandom_range(0, 3)))
                        : AW'($urandom_range(0, 15));
                end
            end
            tick();
            if (rd || rst) check("rand_rdat", cpu_if.r_dat, exp_rdat);
        end
        idle_bus(); rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the CPU data-memory port (d_* signals) of riscv_cpu.
- Decodes each word address:
  - the lower half of the space is forwarded unchanged to the data bram32;
  - the upper half is served by a small MMIO register file. This holds a free-running cycle counter, a program status/halt register, and a byte-wide TX FIFO drained through a valid/ready stream.
- Lets test programs report pass/fail and emit bytes without the bench peeking into memory.

Parameters:
- ADDR_WIDTH, `RAM_ADDR_WIDTH (12), word-address width of the CPU data port.
- DATA_WIDTH, `DATA_WIDTH (32), data word width.
- TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_w_addr  in  ADDR_WIDTH  CPU write word address.
- cpu_w_dat  in  DATA_WIDTH  CPU write data.
- cpu_w_enb  in  1  CPU write strobe.
- cpu_w_byte_enb  in  4  CPU byte enables; bit0 = bits [7:0].
- cpu_r_addr  in  ADDR_WIDTH  CPU read word address.
- cpu_r_enb  in  1  CPU read strobe.
- cpu_r_dat  out  DATA_WIDTH  read data, one cycle after cpu_r_enb.
- mem_w_addr  out  ADDR_WIDTH  to bram32 w_addr.
- mem_w_dat  out  DATA_WIDTH  to bram32 w_dat.
- mem_w_enb  out  1  to bram32 w_enb.
- mem_w_byte_enb  out  4  to bram32 byte_enb.
- mem_r_addr  out  ADDR_WIDTH  to bram32 r_addr.
- mem_r_enb  out  1  to bram32 r_enb.
- mem_r_dat  in  DATA_WIDTH  from bram32 r_dat (1-cycle latency).
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts; pop occurs when tx_valid && tx_ready.
- halted  out  1  STATUS.halt bit.
- pass  out  1  STATUS.pass bit.

Behaviour:
- Decode: addr[ADDR_WIDTH-1] = 0 selects RAM; 1 selects MMIO.
- MMIO register offset is addr[1:0]; remaining upper bits are ignored, so registers alias.
- RAM path, combinational pass-through:
  - mem_w_enb = cpu_w_enb & RAM-selected; mem_r_enb = cpu_r_enb & RAM-selected.
  - mem addresses, data and byte enables are forwarded verbatim.
- Read return path:
  - The read select and MMIO read value are registered on the cycle cpu_r_enb is high.
  - On the following cycle, cpu_r_dat = mem_r_dat if RAM was selected, otherwise the registered MMIO value.
  - When cpu_r_enb is low, the registered MMIO value holds and the select holds.
  - Latency is 1 cycle for both paths, identical to bram32.
- MMIO map (word offsets):
  - 0 CYCLE:
    - Read-only 32-bit counter; increments every cycle after reset and wraps 0xFFFFFFFF->0.
    - Writes are ignored.
  - 1 STATUS:
    - Read/write. bit0 = halt, bit1 = pass, bits[31:8] = code; other bits read 0.
    - Writes honour byte enables per byte lane.
  - 2 TX_DATA:
    - A write with byte_enb[0] = 1 pushes w_dat[7:0]; byte_enb[0] = 0 means no push.
    - Read returns {24'b0, count}, where count is zero-extended to 8 bits.
  - 3 TX_STATUS:
    - bit0 = full, bit1 = empty, bit2 = overflow (sticky).
    - Writing 1 to bit2 with byte_enb[0] clears overflow; other bits read 0.
- MMIO reads sample state before any same-cycle write. Example: read and write of STATUS in one cycle returns the old value.
- TX FIFO:
  - Circular buffer with read/write pointers and count 0..TX_DEPTH.
  - tx_data/tx_valid are driven from the head entry, registered state only.
  - Push when full without a same-cycle pop: byte dropped, overflow set, count unchanged.
  - Push when full with a same-cycle pop: both happen, count stays TX_DEPTH, no overflow.
  - Push when empty: tx_valid rises the next cycle.
  - Pointers wrap modulo TX_DEPTH.
- Reset, synchronous, dominates all same-cycle activity:
  - cpu_r_dat = 0, CYCLE = 0, STATUS = 0, FIFO empty (tx_valid = 0, tx_data = 0), overflow = 0.
  - halted = 0, pass = 0; read select = RAM.
  - Reset mid-operation discards FIFO contents and any pending read return. RAM contents are untouched.
  - RAM-path outputs stay combinational during reset; the CPU is responsible for holding its strobes low.

Test Plan:
- RAM write then read: write 0xDEADBEEF to word 0x010 with byte_enb = 4'b0011, then read 0x010 -> cpu_r_dat = 0x0000BEEF one cycle after cpu_r_enb. No MMIO state changes.
- CYCLE: deassert rst, read 0x800 on the 5th cycle after reset -> value 4. Force the counter to 0xFFFFFFFF -> next cycle it reads 0.
- STATUS: write 0x00ABCD03 with byte_enb = 4'b1111 to 0x801 -> halted = 1, pass = 1, readback 0x00ABCD03. Then write 0 with byte_enb = 4'b0001 -> halted = 0, readback 0x00ABCD00.
- FIFO stream:
  - With tx_ready = 0, push 0x41, 0x42, 0x43 -> TX_DATA reads 3, tx_valid = 1, tx_data = 0x41.
  - Then tx_ready = 1 -> bytes 0x41, 0x42, 0x43 appear on consecutive cycles, then tx_valid = 0 and TX_STATUS = 0x2.
- Overflow:
  - With tx_ready = 0, push 9 bytes -> TX_STATUS = 0x5 (full + overflow), and only the first 8 bytes drain.
  - Write 0x4 to 0x803 -> overflow cleared.
  - Refill to full, then push together with tx_ready = 1 -> no overflow.
- Reset mid-stream: with 4 bytes queued, assert rst for 1 cycle -> tx_valid = 0, STATUS = 0, CYCLE = 0, and RAM word 0x010 is still readable unchanged.
